// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU source-A arbiter: state encoding, source-A
// select codes and the default op width.
package alu_arb_pkg;

  localparam int OP_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SRC_PC    = 2'd0;
  localparam logic [1:0] SRC_A     = 2'd1;
  localparam logic [1:0] SRC_2     = 2'd2;
  localparam logic [1:0] SRC_NOT_A = 2'd3;

  function automatic logic [1:0] idx_to_mask(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational 2-way picker returning a one-hot grant. Round-robin by default;
// ALU_ARB_FIXED_PRIO_EN makes requester 0 win every tie.
module alu_arb_pick
  import alu_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
      2'b11:   grant = 2'b01;
`else
      // On a tie, the requester that did not win last time goes next
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
`endif
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_a_arbiter.sv
// Shares the ALU and its source-A mux between fetch (0) and execute (1).
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_a_arbiter
  import alu_arb_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int OP_W    = OP_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [OP_W-1:0] req1_op,
  input  logic [1:0]      req1_src,
  output logic [1:0]      alu_sel_a,
  output logic [OP_W-1:0] alu_op,
  output logic            alu_start,
  input  logic [31:0]     alu_result,
  output logic [1:0]      rsp_valid,
  output logic [31:0]     rsp_data,
  input  logic [1:0]      rsp_ready
);

  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
    $error("alu_a_arbiter: ALU_LAT must be in 1..15");
  end

  localparam logic [3:0] LAT4 = 4'(ALU_LAT);

  state_t          state_q, state_d;
  logic            g_q;
  logic            last_grant_q;
  logic [3:0]      cnt_q;
  logic [OP_W-1:0] op_q;
  logic [1:0]      src_q;
  logic [31:0]     rsp_data_q;
  logic [1:0]      grant;

  alu_arb_pick u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    alu_sel_a = SRC_PC;
    alu_op    = '0;
    alu_start = 1'b0;
    rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        // Gated by reset so no grant is advertised that the flops cannot take
        req_ready = reset ? grant : 2'b00;
        if (|grant) state_d = BUSY;
      end
      BUSY: begin
        alu_sel_a = src_q;
        alu_op    = op_q;
        alu_start = (cnt_q == LAT4);
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        rsp_valid = idx_to_mask(g_q);
        if (rsp_ready[g_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      g_q          <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      rsp_data_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|grant) begin
            g_q   <= grant[1];
            cnt_q <= LAT4;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) rsp_data_q <= alu_result;
        end
        RESP: begin
`ifndef ALU_ARB_FIXED_PRIO_EN
          if (rsp_ready[g_q]) last_grant_q <= g_q;
`endif
        end
        default: ;
      endcase
    end
  end

  // Operand capture; only observed while BUSY, so it needs no reset
  always_ff @(posedge clk) begin
    if (state_q == IDLE && |grant) begin
      op_q  <= grant[1] ? req1_op : req0_op;
      src_q <= grant[1] ? req1_src : SRC_PC;
    end
  end

  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_alu_a_arbiter.sv
// Self-checking bench for alu_a_arbiter: randomized operations checked against
// a rule-level model of grant choice, drive values and the sampled result.
module tb_alu_a_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req1_src, alu_sel_a, rsp_valid, rsp_ready;
  logic [2:0]  req0_op, req1_op, alu_op;
  logic        alu_start;
  logic [31:0] alu_result, rsp_data;

  int nchk  = 0;
  int nfail = 0;
  int m_last = 1;
  int g;

  alu_a_arbiter #(.ALU_LAT(LAT), .OP_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req1_src   (req1_src),
    .alu_sel_a  (alu_sel_a),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Who should win, from the arbitration rules alone
  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    if (v == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last == 0) ? 1 : 0;
`endif
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_sel"},       32'(alu_sel_a), 32'd0);
    check({tag, "_op"},        32'(alu_op),    32'd0);
    check({tag, "_start"},     32'(alu_start), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;
    check_all_zero("idle");
  endtask

  // One full operation: grant, LAT busy cycles, hold+1 response cycles.
  task automatic run_op(input logic [1:0] v, input int src, input int hold, output int gw);
    logic [1:0]  gm, esel;
    logic [2:0]  eop;
    logic [31:0] eres;
    @(negedge clk);
    req_valid  = v;
    rsp_ready  = 2'b00;
    req0_op    = 3'($urandom);
    req1_op    = 3'($urandom);
    req1_src   = (src < 0) ? 2'($urandom) : 2'(src);
    alu_result = $urandom;
    #1;
    gw   = pick(v, m_last);
    gm   = (gw == 1) ? 2'b10 : 2'b01;
    eop  = (gw == 1) ? req1_op : req0_op;
    esel = (gw == 1) ? req1_src : 2'b00;
    eres = 32'd0;
    check("grant_ready", 32'(req_ready), 32'(gm));
    check("grant_no_start", 32'(alu_start), 32'd0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req_valid  = v & ~gm;
      rsp_ready  = ~gm;
      alu_result = $urandom;
      if (gw == 1) begin
        req1_op  = 3'($urandom);
        req1_src = 2'($urandom);
      end else begin
        req0_op  = 3'($urandom);
      end
      #1;
      if (k == LAT) eres = alu_result;
      check("busy_sel",       32'(alu_sel_a), 32'(esel));
      check("busy_op",        32'(alu_op),    32'(eop));
      check("busy_start",     32'(alu_start), 32'(k == 1));
      check("busy_no_ready",  32'(req_ready), 32'd0);
      check("busy_no_rsp",    32'(rsp_valid), 32'd0);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      alu_result = $urandom;
      rsp_ready  = (h == hold) ? gm : ~gm;
      #1;
      check("rsp_valid",    32'(rsp_valid), 32'(gm));
      check("rsp_data",     rsp_data,       eres);
      check("rsp_sel_zero", 32'(alu_sel_a), 32'd0);
      check("rsp_op_zero",  32'(alu_op),    32'd0);
      check("rsp_no_start", 32'(alu_start), 32'd0);
      check("rsp_no_grant", 32'(req_ready), 32'd0);
    end
`ifndef ALU_ARB_FIXED_PRIO_EN
    m_last = gw;
`endif
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 2'b00;
    rsp_ready  = 2'b00;
    req0_op    = 3'd0;
    req1_op    = 3'd0;
    req1_src   = 2'd0;
    alu_result = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    check("reset_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("post_reset");

    // Single fetch request, then ties, then execute on the ~A path
    run_op(2'b01, -1, 0, g);
    idle_cycle();
    repeat (4) run_op(2'b11, 3, 0, g);
    run_op(2'b10, 3, 0, g);

    // Long response stall with the other requester pending
    run_op(2'b11, -1, 5, g);
    run_op(2'b11, -1, 0, g);
    idle_cycle();

    repeat (12) begin
      run_op(2'($urandom_range(1, 3)), -1, $urandom_range(0, 3), g);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    // Reset asserted in the second busy cycle of an execute operation
    @(negedge clk);
    req_valid = 2'b10;
    req1_src  = 2'd3;
    req1_op   = 3'd5;
    #1;
    check("rst_op_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    #1;
    check("rst_op_start", 32'(alu_start), 32'd1);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("rst_op_busy2_sel", 32'(alu_sel_a), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    check("async_reset_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    reset     = 1'b1;
    m_last    = 1;
    repeat (LAT + 2) idle_cycle();
    run_op(2'b11, -1, 0, g);
    run_op(2'b11, -1, 1, g);
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
